// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: core has priority, host is protected from starvation and may lock the memory.
// Grants are same-cycle combinational and load data returns one cycle later; a denied requester sees its stall/no-grant and must hold its request.
module mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_stall,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_core_rvld,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic              i_host_lock,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_gnt,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_host_rvld,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [15:0]       o_conflict_cnt
);

    typedef enum logic {ARB, LOCK} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        rd_core_q, rd_core_d;
    logic        rd_host_q, rd_host_d;
    logic [15:0] conflict_q, conflict_d;
    logic        force_host;
    logic        core_gnt, host_gnt;

    always_comb begin
        state_d    = state_q;
        core_gnt   = 1'b0;
        host_gnt   = 1'b0;
        force_host = (starve_q == LIMIT);
        case (state_q)
            ARB: begin
                core_gnt = i_core_req & ~force_host;
                host_gnt = i_host_req & (~i_core_req | force_host);
                if (host_gnt && i_host_lock) begin
                    state_d = LOCK;
                end
            end
            LOCK: begin
                // The cycle that samples lock low is still host-only.
                host_gnt = i_host_req;
                if (!i_host_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase

        if (i_host_req && !host_gnt) begin
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
        end else begin
            starve_d = 4'd0;
        end

        rd_core_d = core_gnt & ~i_core_we;
        rd_host_d = host_gnt & ~i_host_we;

        if (i_core_req && i_host_req && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        if (core_gnt) begin
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
            o_mem_re    = ~i_core_we;
            o_mem_we    = i_core_we;
        end else if (host_gnt) begin
            o_mem_addr  = i_host_addr;
            o_mem_wdata = i_host_wdata;
            o_mem_re    = ~i_host_we;
            o_mem_we    = i_host_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ARB;
            starve_q   <= 4'd0;
            rd_core_q  <= 1'b0;
            rd_host_q  <= 1'b0;
            conflict_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_core_q  <= rd_core_d;
            rd_host_q  <= rd_host_d;
            conflict_q <= conflict_d;
        end
    end

    // Return flags are masked by reset so a load issued just before reset never reports.
    assign o_core_gnt     = core_gnt;
    assign o_host_gnt     = host_gnt;
    assign o_core_stall   = i_core_req & ~core_gnt;
    assign o_core_rvld    = rd_core_q & ~i_rst;
    assign o_host_rvld    = rd_host_q & ~i_rst;
    assign o_core_rdata   = o_core_rvld ? i_mem_rdata : '0;
    assign o_host_rdata   = o_host_rvld ? i_mem_rdata : '0;
    assign o_conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for per-cycle arbitration/return, hand sequences for lock, reset and saturation.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_core_req, i_core_we;
    logic [7:0]  i_core_addr;
    logic [31:0] i_core_wdata;
    logic        o_core_gnt, o_core_stall, o_core_rvld;
    logic [31:0] o_core_rdata;
    logic        i_host_req, i_host_we, i_host_lock;
    logic [7:0]  i_host_addr;
    logic [31:0] i_host_wdata;
    logic        o_host_gnt, o_host_rvld;
    logic [31:0] o_host_rdata;
    logic        o_mem_re, o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic [15:0] o_conflict_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_core_req(i_core_req), .i_core_we(i_core_we),
        .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata),
        .o_core_gnt(o_core_gnt), .o_core_stall(o_core_stall),
        .o_core_rdata(o_core_rdata), .o_core_rvld(o_core_rvld),
        .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_lock(i_host_lock),
        .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
        .o_host_gnt(o_host_gnt), .o_host_rdata(o_host_rdata), .o_host_rvld(o_host_rvld),
        .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_conflict_cnt(o_conflict_cnt)
    );

    // Synchronous memory: data valid one cycle after a read strobe, garbage otherwise.
    always @(posedge i_clk) begin
        if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
        if (o_mem_re) i_mem_rdata <= mem[o_mem_addr];
        else          i_mem_rdata <= 32'hBAADF00D;
    end

    typedef struct {
        logic        creq, cwe;
        logic [7:0]  caddr;
        logic [31:0] cwd;
        logic        hreq, hwe, hlock;
        logic [7:0]  haddr;
        logic [31:0] hwd;
        logic        cg, hg, re, we;
        logic [7:0]  maddr;
        logic [31:0] mwd;
        logic        crv, hrv;
        logic [31:0] crd, hrd;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [7:0] caddr,
                         input logic hreq, input logic hwe, input logic hlock, input logic [7:0] haddr);
        i_core_req = creq; i_core_we = cwe; i_core_addr = caddr; i_core_wdata = 32'h0;
        i_host_req = hreq; i_host_we = hwe; i_host_lock = hlock; i_host_addr = haddr; i_host_wdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 32'hA5000000 | 32'(a);
        mem[8'h10] = 32'hDEADBEEF;

        //            creq cwe caddr  cwd            hreq hwe lk haddr  hwd            cg hg re we maddr  mwd            crv hrv crd            hrd            cnt
        vecs[0]  = '{1'b1,1'b0,8'h10,32'h0,         1'b0,1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,1'b1,1'b0,8'h10,32'h0,         1'b0,1'b0,32'h0,         32'h0,         16'd0};
        vecs[1]  = '{1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,32'hDEADBEEF,  32'h0,         16'd0};
        vecs[2]  = '{1'b1,1'b0,8'h20,32'h0,         1'b1,1'b0,1'b0,8'h30,32'h0,         1'b1,1'b0,1'b1,1'b0,8'h20,32'h0,         1'b0,1'b0,32'h0,         32'h0,         16'd0};
        vecs[3]  = '{1'b1,1'b0,8'h20,32'h0,         1'b1,1'b0,1'b0,8'h30,32'h0,         1'b1,1'b0,1'b1,1'b0,8'h20,32'h0,         1'b1,1'b0,32'hA5000020,  32'h0,         16'd1};
        vecs[4]  = '{1'b1,1'b0,8'h20,32'h0,         1'b1,1'b0,1'b0,8'h30,32'h0,         1'b1,1'b0,1'b1,1'b0,8'h20,32'h0,         1'b1,1'b0,32'hA5000020,  32'h0,         16'd2};
        vecs[5]  = '{1'b1,1'b0,8'h20,32'h0,         1'b1,1'b0,1'b0,8'h30,32'h0,         1'b1,1'b0,1'b1,1'b0,8'h20,32'h0,         1'b1,1'b0,32'hA5000020,  32'h0,         16'd3};
        vecs[6]  = '{1'b1,1'b0,8'h20,32'h0,         1'b1,1'b0,1'b0,8'h30,32'h0,         1'b0,1'b1,1'b1,1'b0,8'h30,32'h0,         1'b1,1'b0,32'hA5000020,  32'h0,         16'd4};
        vecs[7]  = '{1'b1,1'b0,8'h20,32'h0,         1'b1,1'b0,1'b0,8'h30,32'h0,         1'b1,1'b0,1'b1,1'b0,8'h20,32'h0,         1'b0,1'b1,32'h0,         32'hA5000030,  16'd5};
        vecs[8]  = '{1'b1,1'b0,8'h01,32'h0,         1'b0,1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,1'b1,1'b0,8'h01,32'h0,         1'b1,1'b0,32'hA5000020,  32'h0,         16'd6};
        vecs[9]  = '{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,1'b0,8'h02,32'h0,         1'b0,1'b1,1'b1,1'b0,8'h02,32'h0,         1'b1,1'b0,32'hA5000001,  32'h0,         16'd6};
        vecs[10] = '{1'b1,1'b0,8'h01,32'h0,         1'b0,1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,1'b1,1'b0,8'h01,32'h0,         1'b0,1'b1,32'h0,         32'hA5000002,  16'd6};
        vecs[11] = '{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,1'b0,8'h02,32'h0,         1'b0,1'b1,1'b1,1'b0,8'h02,32'h0,         1'b1,1'b0,32'hA5000001,  32'h0,         16'd6};
        vecs[12] = '{1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,         1'b0,1'b1,32'h0,         32'hA5000002,  16'd6};
        vecs[13] = '{1'b1,1'b1,8'h40,32'hCAFE0040,  1'b0,1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,1'b0,1'b1,8'h40,32'hCAFE0040,  1'b0,1'b0,32'h0,         32'h0,         16'd6};
        vecs[14] = '{1'b1,1'b0,8'h40,32'h0,         1'b0,1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,1'b1,1'b0,8'h40,32'h0,         1'b0,1'b0,32'h0,         32'h0,         16'd6};
        vecs[15] = '{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b1,1'b0,8'h50,32'h0BAD0050,  1'b0,1'b1,1'b0,1'b1,8'h50,32'h0BAD0050,  1'b1,1'b0,32'hCAFE0040,  32'h0,         16'd6};
        vecs[16] = '{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,1'b0,8'h50,32'h0,         1'b0,1'b1,1'b1,1'b0,8'h50,32'h0,         1'b0,1'b0,32'h0,         32'h0,         16'd6};
        vecs[17] = '{1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,         1'b0,1'b1,32'h0,         32'h0BAD0050,  16'd6};

        // Reset: loads from both sides requested throughout; the grant is live but nothing returns.
        i_rst = 1'b1;
        drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 8'h02);
        next_cycle();
        @(negedge i_clk);
        chk("rst_core_gnt",  32'(o_core_gnt), 32'd1);
        chk("rst_mem_re",    32'(o_mem_re), 32'd1);
        chk("rst_core_rvld", 32'(o_core_rvld), 32'd0);
        chk("rst_host_rvld", 32'(o_host_rvld), 32'd0);
        chk("rst_core_rdata", o_core_rdata, 32'h0);
        chk("rst_host_rdata", o_host_rdata, 32'h0);
        chk("rst_cnt",       32'(o_conflict_cnt), 32'd0);
        next_cycle();
        i_rst = 1'b0;

        for (int v = 0; v < 18; v++) begin
            i_core_req = vecs[v].creq; i_core_we = vecs[v].cwe;
            i_core_addr = vecs[v].caddr; i_core_wdata = vecs[v].cwd;
            i_host_req = vecs[v].hreq; i_host_we = vecs[v].hwe; i_host_lock = vecs[v].hlock;
            i_host_addr = vecs[v].haddr; i_host_wdata = vecs[v].hwd;
            @(negedge i_clk);
            chk($sformatf("v%0d_core_gnt", v),   32'(o_core_gnt),   32'(vecs[v].cg));
            chk($sformatf("v%0d_host_gnt", v),   32'(o_host_gnt),   32'(vecs[v].hg));
            chk($sformatf("v%0d_stall", v),      32'(o_core_stall), 32'(vecs[v].creq & ~vecs[v].cg));
            chk($sformatf("v%0d_mem_re", v),     32'(o_mem_re),     32'(vecs[v].re));
            chk($sformatf("v%0d_mem_we", v),     32'(o_mem_we),     32'(vecs[v].we));
            chk($sformatf("v%0d_mem_addr", v),   32'(o_mem_addr),   32'(vecs[v].maddr));
            chk($sformatf("v%0d_mem_wdata", v),  o_mem_wdata,       vecs[v].mwd);
            chk($sformatf("v%0d_core_rvld", v),  32'(o_core_rvld),  32'(vecs[v].crv));
            chk($sformatf("v%0d_host_rvld", v),  32'(o_host_rvld),  32'(vecs[v].hrv));
            chk($sformatf("v%0d_core_rdata", v), o_core_rdata,      vecs[v].crd);
            chk($sformatf("v%0d_host_rdata", v), o_host_rdata,      vecs[v].hrd);
            chk($sformatf("v%0d_cnt", v),        32'(o_conflict_cnt), 32'(vecs[v].cnt));
            next_cycle();
        end

        // Host store with lock: granted alone, then core stalls through both lock cycles and the unlock cycle.
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h60);
        @(negedge i_clk);
        chk("lk0_host_gnt", 32'(o_host_gnt), 32'd1);
        chk("lk0_mem_we",   32'(o_mem_we), 32'd1);
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1, 1'b0, 8'h11, 1'b1, 1'b1, (c < 3), 8'h60);
            @(negedge i_clk);
            chk($sformatf("lk%0d_core_gnt", c), 32'(o_core_gnt), 32'd0);
            chk($sformatf("lk%0d_stall", c),    32'(o_core_stall), 32'd1);
            chk($sformatf("lk%0d_host_gnt", c), 32'(o_host_gnt), 32'd1);
            next_cycle();
        end
        drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge i_clk);
        chk("lk4_core_gnt", 32'(o_core_gnt), 32'd1);
        chk("lk4_stall",    32'(o_core_stall), 32'd0);
        next_cycle();

        // Reset the cycle after a granted core load; a locked host load in the reset cycle must not return.
        drive(1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge i_clk);
        chk("r0_core_gnt", 32'(o_core_gnt), 32'd1);
        next_cycle();
        i_rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02);
        @(negedge i_clk);
        chk("r1_core_rvld",  32'(o_core_rvld), 32'd0);
        chk("r1_core_rdata", o_core_rdata, 32'h0);
        chk("r1_host_gnt",   32'(o_host_gnt), 32'd1);
        next_cycle();
        i_rst = 1'b0;
        drive(1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 8'h30);
        @(negedge i_clk);
        chk("r2_core_gnt",  32'(o_core_gnt), 32'd1);
        chk("r2_host_gnt",  32'(o_host_gnt), 32'd0);
        chk("r2_host_rvld", 32'(o_host_rvld), 32'd0);
        chk("r2_cnt",       32'(o_conflict_cnt), 32'd0);
        next_cycle();

        // Conflict counter saturation: one conflict counted at r2, then keep both requesting.
        repeat (65533) @(posedge i_clk);
        @(negedge i_clk);
        chk("sat_fffe", 32'(o_conflict_cnt), 32'h0000FFFE);
        repeat (12) @(posedge i_clk);
        @(negedge i_clk);
        chk("sat_ffff", 32'(o_conflict_cnt), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
